time_of_day_counter: RTL and testbench

//  Consumes the slow square-wave timebase produced by the design's clock divider and turns it into a BCD hh:mm:ss time of day.

---
 rtl/time_of_day_counter.sv | 209 ++++++++++++++++++++
 tb/tb_time_of_day_counter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_of_day_counter.sv
// BCD hh:mm:ss time of day driven by a synchronised 1 Hz timebase.
// Optional 12-hour AM/PM mode: define TWELVE_HOUR_EN.
module time_of_day_counter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       run,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
`ifdef TWELVE_HOUR_EN
    input  logic       load_pm,
    output logic       pm,
`endif
    output logic       load_err,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       day_rollover
);

    localparam int MSB = SYNC_STAGES - 1;

    typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;

    state_t state_q, state_d;

    logic [MSB:0] sync_q;
    logic [MSB:0] fill_q;
    logic         edge_q;
    logic         arm_q;
    logic         rise;
    logic         accept;
    logic         ready_q;
    logic         ld_ok;

    logic [7:0] hh_q, hh_d;
    logic [7:0] mm_q, mm_d;
    logic [7:0] ss_q, ss_d;
    logic [7:0] ld_hh_q, ld_mm_q, ld_ss_q;
    logic       sp_q, sp_d;
    logic       dr_q, dr_d;
`ifdef TWELVE_HOUR_EN
    logic       pm_q, pm_d;
    logic       ld_pm_q;
`endif

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // fill_q/arm_q hold off edge detection until edge_q holds a real
    // sample, so a tick_in already high at reset release is not a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
            edge_q <= 1'b0;
            arm_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[MSB-1:0], tick_in};
            fill_q <= {fill_q[MSB-1:0], 1'b1};
            edge_q <= sync_q[MSB];
            arm_q  <= fill_q[MSB];
        end
    end

    assign rise   = sync_q[MSB] & ~edge_q & arm_q;
    assign accept = load_valid & ready_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept)   state_d = LOAD;
                else if (run) state_d = RUN;
            end
            RUN: begin
                if (accept)    state_d = LOAD;
                else if (!run) state_d = IDLE;
            end
            LOAD:    state_d = run ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef TWELVE_HOUR_EN
    assign ld_ok = bcd_ok(ld_ss_q, 8'h59) && bcd_ok(ld_mm_q, 8'h59) &&
                   bcd_ok(ld_hh_q, 8'h12) && (ld_hh_q != 8'h00);
`else
    assign ld_ok = bcd_ok(ld_ss_q, 8'h59) && bcd_ok(ld_mm_q, 8'h59) &&
                   bcd_ok(ld_hh_q, 8'h23);
`endif

    always_comb begin
        hh_d = hh_q;
        mm_d = mm_q;
        ss_d = ss_q;
        sp_d = 1'b0;
        dr_d = 1'b0;
`ifdef TWELVE_HOUR_EN
        pm_d = pm_q;
`endif
        if (state_q == LOAD) begin
            if (ld_ok) begin
                hh_d = ld_hh_q;
                mm_d = ld_mm_q;
                ss_d = ld_ss_q;
`ifdef TWELVE_HOUR_EN
                pm_d = ld_pm_q;
`endif
            end
        end else if (state_q == RUN && run && rise && !accept) begin
            sp_d = 1'b1;
            if (ss_q == 8'h59) begin
                ss_d = 8'h00;
                if (mm_q == 8'h59) begin
                    mm_d = 8'h00;
`ifdef TWELVE_HOUR_EN
                    if (hh_q == 8'h12) begin
                        hh_d = 8'h01;
                    end else begin
                        hh_d = bcd_inc(hh_q);
                        if (hh_q == 8'h11) begin
                            pm_d = ~pm_q;
                            dr_d = pm_q;
                        end
                    end
`else
                    if (hh_q == 8'h23) begin
                        hh_d = 8'h00;
                        dr_d = 1'b1;
                    end else begin
                        hh_d = bcd_inc(hh_q);
                    end
`endif
                end else begin
                    mm_d = bcd_inc(mm_q);
                end
            end else begin
                ss_d = bcd_inc(ss_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
`ifdef TWELVE_HOUR_EN
            hh_q    <= 8'h12;
            pm_q    <= 1'b0;
            ld_pm_q <= 1'b0;
`else
            hh_q    <= 8'h00;
`endif
            mm_q    <= 8'h00;
            ss_q    <= 8'h00;
            sp_q    <= 1'b0;
            dr_q    <= 1'b0;
            ld_hh_q <= 8'h00;
            ld_mm_q <= 8'h00;
            ld_ss_q <= 8'h00;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != LOAD);
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            sp_q    <= sp_d;
            dr_q    <= dr_d;
`ifdef TWELVE_HOUR_EN
            pm_q    <= pm_d;
`endif
            if (accept) begin
                ld_hh_q <= load_hh;
                ld_mm_q <= load_mm;
                ld_ss_q <= load_ss;
`ifdef TWELVE_HOUR_EN
                ld_pm_q <= load_pm;
`endif
            end
        end
    end

    assign load_ready   = ready_q;
    assign load_err     = (state_q == LOAD) & ~ld_ok;
    assign hh           = hh_q;
    assign mm           = mm_q;
    assign ss           = ss_q;
    assign sec_pulse    = sp_q;
    assign day_rollover = dr_q;
`ifdef TWELVE_HOUR_EN
    assign pm           = pm_q;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboarded directed bench for time_of_day_counter.
// Define TWELVE_HOUR_EN to exercise the AM/PM build instead.
module tb_time_of_day_counter;

    logic       clk = 1'b0;
    logic       rst, tick_in, run, load_valid;
    logic       load_ready, load_err, sec_pulse, day_rollover;
    logic [7:0] load_hh, load_mm, load_ss, hh, mm, ss;
`ifdef TWELVE_HOUR_EN
    logic       load_pm, pm;
`endif

    int total = 0;
    int bad   = 0;
    int n_sp  = 0, n_dr = 0, n_err = 0;
    int s_sp, s_dr, s_err;
    int h = 0, m = 0, s = 0;
    int lat;

    typedef struct {
        string       tag;
        logic [23:0] t;
        int          sp;
        int          dr;
        int          err;
    } exp_t;

    exp_t sbq[$];

    time_of_day_counter #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .run(run),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
`ifdef TWELVE_HOUR_EN
        .load_pm(load_pm), .pm(pm),
`endif
        .load_err(load_err), .hh(hh), .mm(mm), .ss(ss),
        .sec_pulse(sec_pulse), .day_rollover(day_rollover)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_sp  <= n_sp + int'(sec_pulse === 1'b1);
        n_dr  <= n_dr + int'(day_rollover === 1'b1);
        n_err <= n_err + int'(load_err === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int adv();
        s++;
        if (s == 60) begin
            s = 0; m++;
            if (m == 60) begin
                m = 0; h++;
                if (h == 24) begin
                    h = 0;
                    return 1;
                end
            end
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic begin_step(input string tag, input int sp, input int dr, input int err);
        exp_t e;
        e.tag = tag;
        e.t   = {bcd(h), bcd(m), bcd(s)};
        e.sp  = sp;
        e.dr  = dr;
        e.err = err;
        sbq.push_back(e);
        s_sp  = n_sp;
        s_dr  = n_dr;
        s_err = n_err;
    endtask

    task automatic end_step();
        exp_t e;
        e = sbq.pop_front();
        chk({e.tag, "_time"}, {8'h00, hh, mm, ss}, {8'h00, e.t});
        chk({e.tag, "_sp"}, n_sp - s_sp, e.sp);
        chk({e.tag, "_dr"}, n_dr - s_dr, e.dr);
        chk({e.tag, "_err"}, n_err - s_err, e.err);
    endtask

    task automatic rise(output int l);
        l = 0;
        tick_in = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            cyc(1);
            if (sec_pulse === 1'b1 && l == 0) l = c;
        end
        tick_in = 1'b0;
        cyc(4);
    endtask

    task automatic load(input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls);
        int w = 0;
        while (load_ready !== 1'b1 && w < 10) begin
            cyc(1);
            w++;
        end
        chk("ld_ready", load_ready, 1);
        load_valid = 1'b1;
        load_hh = lh;
        load_mm = lm;
        load_ss = ls;
        cyc(1);
        load_valid = 1'b0;
        load_hh = 8'hFF;
        load_mm = 8'hFF;
        load_ss = 8'hFF;
        cyc(4);
    endtask

    initial begin
        int d;
        rst = 1'b1; run = 1'b1; tick_in = 1'b1; load_valid = 1'b0;
        load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
`ifdef TWELVE_HOUR_EN
        load_pm = 1'b0;
`endif
        cyc(3);
        chk("rst_ready", load_ready, 0);
        chk("rst_sp", sec_pulse, 0);
        chk("rst_err", load_err, 0);
`ifdef TWELVE_HOUR_EN
        chk("rst_time12", {pm, hh, mm, ss}, {1'b0, 24'h120000});
        rst = 1'b0;
        cyc(10);
        tick_in = 1'b0;
        cyc(4);
        chk("rst_tick12", {pm, hh, mm, ss}, {1'b0, 24'h120000});

        load_pm = 1'b1;
        s_dr = n_dr;
        load(8'h11, 8'h59, 8'h59);
        chk("pm_load", {pm, hh, mm, ss}, {1'b1, 24'h115959});
        rise(lat);
        chk("pm_wrap", {pm, hh, mm, ss}, {1'b0, 24'h120000});
        chk("pm_dr", n_dr - s_dr, 1);

        load_pm = 1'b0;
        load(8'h11, 8'h59, 8'h59);
        s_dr = n_dr;
        rise(lat);
        chk("am_noon", {pm, hh, mm, ss}, {1'b1, 24'h120000});
        chk("am_noon_dr", n_dr - s_dr, 0);

        load(8'h12, 8'h59, 8'h59);
        rise(lat);
        chk("h12_to_1", {pm, hh, mm, ss}, {1'b0, 24'h010000});

        s_err = n_err;
        load(8'h00, 8'h00, 8'h00);
        chk("h00_err", n_err - s_err, 1);
        load(8'h13, 8'h00, 8'h00);
        chk("h13_err", n_err - s_err, 2);
        chk("err_hold", {pm, hh, mm, ss}, {1'b0, 24'h010000});

        load_pm = 1'b1;
        load(8'h05, 8'h00, 8'h00);
        tick_in = 1'b1;
        cyc(5);
        rst = 1'b1;
        #1;
        chk("rst_mid12", {pm, hh, mm, ss}, {1'b0, 24'h120000});
        cyc(2);
        tick_in = 1'b0;
        rst = 1'b0;
        cyc(4);
`else
        rst = 1'b0;
        begin_step("rst_tick", 0, 0, 0);
        cyc(10);
        tick_in = 1'b0;
        cyc(4);
        end_step();

        d = adv();
        begin_step("first", 1, d, 0);
        rise(lat);
        chk("latency", lat, 3);
        end_step();

        h = 23; m = 59; s = 58;
        begin_step("ld235958", 0, 0, 0);
        load(8'h23, 8'h59, 8'h58);
        end_step();
        for (int i = 0; i < 2; i++) begin
            d = adv();
            begin_step("wrap", 1, d, 0);
            rise(lat);
            end_step();
        end

        h = 9; m = 59; s = 59;
        begin_step("ld095959", 0, 0, 0);
        load(8'h09, 8'h59, 8'h59);
        end_step();
        d = adv();
        begin_step("carry_hh", 1, d, 0);
        rise(lat);
        end_step();

        h = 13; m = 49; s = 59;
        begin_step("ld134959", 0, 0, 0);
        load(8'h13, 8'h49, 8'h59);
        end_step();
        d = adv();
        begin_step("carry_mm", 1, d, 0);
        rise(lat);
        end_step();

        begin_step("bad_h24", 0, 0, 1);
        load(8'h24, 8'h00, 8'h00);
        end_step();
        begin_step("bad_s5A", 0, 0, 1);
        load(8'h00, 8'h00, 8'h5A);
        end_step();
        begin_step("bad_m60", 0, 0, 1);
        load(8'h00, 8'h60, 8'h00);
        end_step();
        begin_step("bad_h1A", 0, 0, 1);
        load(8'h1A, 8'h00, 8'h00);
        end_step();

        h = 10; m = 0; s = 0;
        begin_step("ld_vs_rise", 0, 0, 0);
        tick_in = 1'b1;
        cyc(2);
        load_valid = 1'b1;
        load_hh = 8'h10; load_mm = 8'h00; load_ss = 8'h00;
        cyc(1);
        load_valid = 1'b0;
        load_hh = 8'hFF; load_mm = 8'hFF; load_ss = 8'hFF;
        cyc(4);
        tick_in = 1'b0;
        cyc(4);
        end_step();

        d = adv();
        begin_step("after_ld", 1, d, 0);
        rise(lat);
        end_step();

        run = 1'b0;
        cyc(2);
        begin_step("frozen", 0, 0, 0);
        for (int i = 0; i < 5; i++) rise(lat);
        end_step();
        run = 1'b1;
        cyc(2);
        d = adv();
        begin_step("resume", 1, d, 0);
        rise(lat);
        end_step();

        load_valid = 1'b1;
        load_hh = 8'h05; load_mm = 8'h06; load_ss = 8'h07;
        cyc(1);
        rst = 1'b1;
        #1;
        chk("rst_mid_time", {8'h00, hh, mm, ss}, 32'h0);
        chk("rst_mid_ready", load_ready, 0);
        chk("rst_mid_err", load_err, 0);
        cyc(2);
        load_valid = 1'b0;
        rst = 1'b0;
        h = 0; m = 0; s = 0;
        begin_step("rst_pend", 0, 0, 0);
        cyc(4);
        end_step();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
